// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard beside decode: per-register outstanding-writer
// counts, source/destination stall generation and write-back bypass.
module decode_scoreboard #(
  parameter int NUM_REGS    = 8,
  parameter int REG_ADDR_W  = 3,
  parameter int MAX_PER_REG = 3,
  parameter int MAX_TOTAL   = 4,
  parameter int CNT_W       = 2,
  parameter int TOT_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IssueValid,
  input  logic [REG_ADDR_W-1:0] IssueRs,
  input  logic                  IssueRsValid,
  input  logic [REG_ADDR_W-1:0] IssueRt,
  input  logic                  IssueRtValid,
  input  logic                  IssueWrEn,
  input  logic [REG_ADDR_W-1:0] IssueWrReg,
  input  logic                  RetireValid,
  input  logic [REG_ADDR_W-1:0] RetireReg,
  input  logic                  Flush,
  output logic                  Stall,
  output logic                  Accept,
  output logic [NUM_REGS-1:0]   Pending,
  output logic [TOT_W-1:0]      InflightCount,
  output logic                  Err
);

  localparam logic [CNT_W-1:0] MAX_PR = CNT_W'(MAX_PER_REG);
  localparam logic [TOT_W-1:0] MAX_TT = TOT_W'(MAX_TOTAL);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [TOT_W-1:0] ONE_T  = TOT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [TOT_W-1:0]    tot_q, tot_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                err_q, err_d;

  logic             rs_ok, rt_ok, wr_ok, ret_ok;
  logic [CNT_W-1:0] rs_cnt, rt_cnt, wr_cnt, ret_cnt;
  logic             rs_haz, rt_haz, wr_full, tot_full;
  logic             rs_use, rt_use, wr_use, ret_eff;
  logic             bad_sel, stall_d, accept_d, inc_tot;

  // Out-of-range selects read as count 0 and are ignored
  always_comb begin
    rs_ok   = 32'(IssueRs) < 32'(NUM_REGS);
    rt_ok   = 32'(IssueRt) < 32'(NUM_REGS);
    wr_ok   = 32'(IssueWrReg) < 32'(NUM_REGS);
    ret_ok  = 32'(RetireReg) < 32'(NUM_REGS);
    rs_cnt  = '0;
    rt_cnt  = '0;
    wr_cnt  = '0;
    ret_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (IssueRs == REG_ADDR_W'(i))    rs_cnt  = cnt_q[i];
      if (IssueRt == REG_ADDR_W'(i))    rt_cnt  = cnt_q[i];
      if (IssueWrReg == REG_ADDR_W'(i)) wr_cnt  = cnt_q[i];
      if (RetireReg == REG_ADDR_W'(i))  ret_cnt = cnt_q[i];
    end
  end

  always_comb begin
    rs_use  = IssueRsValid & rs_ok;
    rt_use  = IssueRtValid & rt_ok;
    wr_use  = IssueWrEn & wr_ok;
    ret_eff = RetireValid & ret_ok & (ret_cnt != '0);

    rs_haz = rs_use & (rs_cnt != '0) &
             ~(ret_eff & (RetireReg == IssueRs) & (rs_cnt == ONE_C));
    rt_haz = rt_use & (rt_cnt != '0) &
             ~(ret_eff & (RetireReg == IssueRt) & (rt_cnt == ONE_C));
    wr_full = wr_use & (wr_cnt == MAX_PR) &
              ~(ret_eff & (RetireReg == IssueWrReg));
    tot_full = wr_use & (tot_q == MAX_TT) & ~ret_eff;

    stall_d  = IssueValid & ~rst &
               (rs_haz | rt_haz | wr_full | tot_full);
    accept_d = IssueValid & ~rst & ~stall_d & ~Flush;
    inc_tot  = accept_d & wr_use;

    bad_sel = (RetireValid & ~ret_ok) |
              (IssueValid & ((IssueRsValid & ~rs_ok) |
                             (IssueRtValid & ~rt_ok) |
                             (IssueWrEn & ~wr_ok)));
  end

  always_comb begin
    tot_d  = tot_q;
    pend_d = pend_q;
    err_d  = err_q | bad_sel | (RetireValid & ret_ok & (ret_cnt == '0));
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_tot & (IssueWrReg == REG_ADDR_W'(i)))
        cnt_d[i] = cnt_d[i] + ONE_C;
      if (ret_eff & (RetireReg == REG_ADDR_W'(i)))
        cnt_d[i] = cnt_d[i] - ONE_C;
      if (Flush)
        cnt_d[i] = '0;
      pend_d[i] = cnt_d[i] != '0;
    end
    if (inc_tot) tot_d = tot_d + ONE_T;
    if (ret_eff) tot_d = tot_d - ONE_T;
    if (Flush)   tot_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      tot_q  <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      tot_q  <= tot_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign Stall         = stall_d;
  assign Accept        = accept_d;
  assign Pending       = pend_q;
  assign InflightCount = tot_q;
  assign Err           = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed self-checking bench for decode_scoreboard.
module tb_decode_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       IssueValid;
  logic [2:0] IssueRs;
  logic       IssueRsValid;
  logic [2:0] IssueRt;
  logic       IssueRtValid;
  logic       IssueWrEn;
  logic [2:0] IssueWrReg;
  logic       RetireValid;
  logic [2:0] RetireReg;
  logic       Flush;
  logic       Stall;
  logic       Accept;
  logic [7:0] Pending;
  logic [2:0] InflightCount;
  logic       Err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_scoreboard dut (
    .clk(clk), .rst(rst),
    .IssueValid(IssueValid),
    .IssueRs(IssueRs), .IssueRsValid(IssueRsValid),
    .IssueRt(IssueRt), .IssueRtValid(IssueRtValid),
    .IssueWrEn(IssueWrEn), .IssueWrReg(IssueWrReg),
    .RetireValid(RetireValid), .RetireReg(RetireReg),
    .Flush(Flush),
    .Stall(Stall), .Accept(Accept),
    .Pending(Pending), .InflightCount(InflightCount),
    .Err(Err)
  );

  task automatic idle();
    IssueValid = 0; IssueRs = 0; IssueRsValid = 0;
    IssueRt = 0; IssueRtValid = 0;
    IssueWrEn = 0; IssueWrReg = 0;
    RetireValid = 0; RetireReg = 0; Flush = 0;
  endtask

  // inputs change 1 time unit after posedge, checks 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic wr(input logic [2:0] r);
    IssueValid = 1; IssueWrEn = 1; IssueWrReg = r;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    IssueValid = 1; IssueWrEn = 1; IssueWrReg = 3;
    IssueRsValid = 1; IssueRs = 3;
    #1;
    n_tests++;
    if (Stall !== 1'b0 || Accept !== 1'b0) begin
      $display("FAIL reset_gate: Stall=%b Accept=%b want 0 0", Stall, Accept);
      n_fail++;
    end
    @(posedge clk); #1;
    rst = 0; idle(); #1;
    n_tests++;
    if (Pending !== 8'h00 || InflightCount !== 3'd0 || Err !== 1'b0) begin
      $display("FAIL reset_state: P=%h N=%0d E=%b want 00 0 0",
               Pending, InflightCount, Err);
      n_fail++;
    end
  endtask

  task automatic test_issue_hazard();
    wr(3);
    n_tests++;
    if (Accept !== 1'b1) begin
      $display("FAIL issue_accept: Accept=%b want 1", Accept);
      n_fail++;
    end
    step();
    n_tests++;
    if (Pending !== 8'h08 || InflightCount !== 3'd1) begin
      $display("FAIL issue_pend: P=%h N=%0d want 08 1",
               Pending, InflightCount);
      n_fail++;
    end
    IssueValid = 1; IssueRsValid = 1; IssueRs = 3; #1;
    n_tests++;
    if (Stall !== 1'b1 || Accept !== 1'b0) begin
      $display("FAIL rs_hazard: Stall=%b Accept=%b want 1 0", Stall, Accept);
      n_fail++;
    end
  endtask

  task automatic test_bypass();
    RetireValid = 1; RetireReg = 3; #1;
    n_tests++;
    if (Stall !== 1'b0 || Accept !== 1'b1) begin
      $display("FAIL bypass: Stall=%b Accept=%b want 0 1", Stall, Accept);
      n_fail++;
    end
    step();
    n_tests++;
    if (Pending !== 8'h00 || InflightCount !== 3'd0) begin
      $display("FAIL bypass_pend: P=%h N=%0d want 00 0",
               Pending, InflightCount);
      n_fail++;
    end
  endtask

  task automatic test_total_limit();
    for (int r = 1; r <= 4; r++) begin
      wr(3'(r));
      step();
    end
    n_tests++;
    if (InflightCount !== 3'd4 || Pending !== 8'h1e) begin
      $display("FAIL total_fill: N=%0d P=%h want 4 1e",
               InflightCount, Pending);
      n_fail++;
    end
    wr(5);
    n_tests++;
    if (Stall !== 1'b1) begin
      $display("FAIL total_full: Stall=%b want 1", Stall);
      n_fail++;
    end
    RetireValid = 1; RetireReg = 1; #1;
    n_tests++;
    if (Stall !== 1'b0 || Accept !== 1'b1) begin
      $display("FAIL total_bypass: Stall=%b Accept=%b want 0 1",
               Stall, Accept);
      n_fail++;
    end
    step();
    n_tests++;
    if (InflightCount !== 3'd4 || Pending !== 8'h3c) begin
      $display("FAIL total_swap: N=%0d P=%h want 4 3c",
               InflightCount, Pending);
      n_fail++;
    end
    Flush = 1; #1;
    step();
    n_tests++;
    if (InflightCount !== 3'd0 || Pending !== 8'h00) begin
      $display("FAIL flush_clean: N=%0d P=%h want 0 00",
               InflightCount, Pending);
      n_fail++;
    end
  endtask

  task automatic test_per_reg_limit();
    for (int k = 0; k < 3; k++) begin
      wr(6);
      step();
    end
    n_tests++;
    if (InflightCount !== 3'd3 || Pending !== 8'h40) begin
      $display("FAIL per_reg_fill: N=%0d P=%h want 3 40",
               InflightCount, Pending);
      n_fail++;
    end
    wr(6);
    n_tests++;
    if (Stall !== 1'b1) begin
      $display("FAIL per_reg_full: Stall=%b want 1", Stall);
      n_fail++;
    end
    RetireValid = 1; RetireReg = 6; #1;
    n_tests++;
    if (Stall !== 1'b0) begin
      $display("FAIL per_reg_bypass: Stall=%b want 0", Stall);
      n_fail++;
    end
    step();
    IssueValid = 1; IssueRsValid = 1; IssueRs = 0; #1;
    n_tests++;
    if (Stall !== 1'b0 || Accept !== 1'b1) begin
      $display("FAIL reader_r0: Stall=%b Accept=%b want 0 1", Stall, Accept);
      n_fail++;
    end
    step();
    n_tests++;
    if (InflightCount !== 3'd3 || Pending !== 8'h40) begin
      $display("FAIL reader_nochg: N=%0d P=%h want 3 40",
               InflightCount, Pending);
      n_fail++;
    end
  endtask

  task automatic test_flush();
    logic e0;
    e0 = Err;
    wr(1);
    Flush = 1; #1;
    n_tests++;
    if (Accept !== 1'b0) begin
      $display("FAIL flush_accept: Accept=%b want 0", Accept);
      n_fail++;
    end
    step();
    n_tests++;
    if (Pending !== 8'h00 || InflightCount !== 3'd0 || Err !== e0) begin
      $display("FAIL flush_state: P=%h N=%0d E=%b want 00 0 %b",
               Pending, InflightCount, Err, e0);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    wr(5);
    step();
    wr(5);
    RetireValid = 1; RetireReg = 5; #1;
    n_tests++;
    if (Accept !== 1'b1) begin
      $display("FAIL b2b_accept: Accept=%b want 1", Accept);
      n_fail++;
    end
    step();
    n_tests++;
    if (Pending !== 8'h20 || InflightCount !== 3'd1) begin
      $display("FAIL b2b_net: P=%h N=%0d want 20 1", Pending, InflightCount);
      n_fail++;
    end
    IssueValid = 1; IssueRtValid = 1; IssueRt = 5; #1;
    n_tests++;
    if (Stall !== 1'b1) begin
      $display("FAIL rt_hazard: Stall=%b want 1", Stall);
      n_fail++;
    end
    IssueValid = 0; #1;
    n_tests++;
    if (Stall !== 1'b0 || Accept !== 1'b0) begin
      $display("FAIL stall_gate: Stall=%b Accept=%b want 0 0", Stall, Accept);
      n_fail++;
    end
    Flush = 1; #1;
    step();
  endtask

  task automatic test_underflow();
    RetireValid = 1; RetireReg = 2; #1;
    step();
    n_tests++;
    if (Err !== 1'b1 || Pending !== 8'h00 || InflightCount !== 3'd0) begin
      $display("FAIL underflow: E=%b P=%h N=%0d want 1 00 0",
               Err, Pending, InflightCount);
      n_fail++;
    end
    wr(2);
    step();
    RetireValid = 1; RetireReg = 2; #1;
    step();
    n_tests++;
    if (Pending !== 8'h00 || InflightCount !== 3'd0) begin
      $display("FAIL underflow_cnt: P=%h N=%0d want 00 0",
               Pending, InflightCount);
      n_fail++;
    end
    Flush = 1; #1;
    step();
    n_tests++;
    if (Err !== 1'b1) begin
      $display("FAIL err_sticky: Err=%b want 1", Err);
      n_fail++;
    end
    rst = 1; #1;
    step();
    rst = 0; #1;
    n_tests++;
    if (Err !== 1'b0) begin
      $display("FAIL err_clear: Err=%b want 0", Err);
      n_fail++;
    end
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_issue_hazard();
    test_bypass();
    test_total_limit();
    test_per_reg_limit();
    test_flush();
    test_back_to_back();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Parametrised register-hazard scoreboard that sits beside the decode stage of the pipelined core.
- Tracks, per architectural register, how many issued instructions will still write it.
- Stalls decode when a source operand or the destination is not safe to use.
- Generalises the single-cycle decode to configurable register count, in-flight depth and write-back bypass, which the unpipelined decode does not provide.

Parameters:
- NUM_REGS, 8, number of architectural registers.
- REG_ADDR_W, 3, register select width; must satisfy 2**REG_ADDR_W >= NUM_REGS.
- MAX_PER_REG, 3, maximum outstanding writers per register.
- MAX_TOTAL, 4, maximum outstanding writers across all registers.
- CNT_W, 2, per-register counter width; must hold MAX_PER_REG.
- TOT_W, 3, total counter width; must hold MAX_TOTAL.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- IssueValid  in  1  decode presents an instruction this cycle.
- IssueRs  in  REG_ADDR_W  first source register.
- IssueRsValid  in  1  instruction reads Rs.
- IssueRt  in  REG_ADDR_W  second source register.
- IssueRtValid  in  1  instruction reads Rt (R-format/store).
- IssueWrEn  in  1  instruction writes a register.
- IssueWrReg  in  REG_ADDR_W  destination register (r7 for link).
- RetireValid  in  1  write-back commits a register write this cycle.
- RetireReg  in  REG_ADDR_W  register being written back.
- Flush  in  1  squash all in-flight instructions (taken branch/jump/exception).
- Stall  out  1  combinational; decode must hold its instruction.
- Accept  out  1  combinational; IssueValid & ~Stall & ~Flush.
- Pending  out  NUM_REGS  registered; bit i set when count[i] != 0.
- InflightCount  out  TOT_W  registered total of outstanding writers.
- Err  out  1  sticky error flag.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - all count[i]=0, total=0, Pending=0, InflightCount=0, Err=0.
  - Stall=0 and Accept=0 while rst is high, since IssueValid is ignored.
- Source hazard for a source s: its valid bit is set and count[s]!=0.
  - Exception (bypass): RetireValid & RetireReg==s & count[s]==1 clears the hazard. Write-back data reaches the register-file bypass the same cycle.
- Stall is asserted by any of:
  - Rs hazard;
  - Rt hazard;
  - IssueWrEn & count[IssueWrReg]==MAX_PER_REG and no same-cycle retire to that register;
  - IssueWrEn & total==MAX_TOTAL and no same-cycle retire.
- Stall is gated by IssueValid; it is 0 when IssueValid=0.
- Update on each posedge (no rst, no Flush):
  - Accept & IssueWrEn increments count[IssueWrReg]; RetireValid decrements count[RetireReg].
  - Issue and retire to the same register in one cycle: net count unchanged.
  - total changes by (+1 issue write) + (-1 retire); both together leave it unchanged.
  - Non-writing instructions (stores, branches, halt) change no counter.
- Flush:
  - Next cycle all counters are 0.
  - Same-cycle issue and retire are discarded; Accept=0.
  - Err is not cleared.
- Err (set at posedge, held until rst):
  - RetireValid with count[RetireReg]==0 (retire underflow); the counter stays at 0.
  - Any select >= NUM_REGS with its valid or enable bit set; that access is ignored.
- Latency:
  - Pending and InflightCount reflect an accepted issue or retire one cycle later.
  - Stall reflects a retire in the same cycle via the bypass rule.
- There is no register hard-wired to zero; every register is tracked.

Test Plan:
1. Reset, then issue WrEn WrReg=3 → Accept=1; next cycle Pending=0x08 and InflightCount=1. Issue Rs=3 RsValid=1 → Stall=1.
2. From scenario 1, present RetireValid RetireReg=3 in the same cycle as the Rs=3 reader → Stall=0 and Accept=1; next cycle Pending=0x00.
3. Issue four writes to regs 1,2,3,4 → InflightCount=4. A fifth write to reg 5 → Stall=1. A retire of reg 1 in the same cycle → Stall=0, and InflightCount stays 4.
4. Issue three writes to reg 6 → a fourth write to reg 6 gives Stall=1 (MAX_PER_REG). A non-writing reader of reg 0 → Stall=0.
5. With InflightCount=3, assert Flush together with IssueValid WrEn → Accept=0; next cycle Pending=0, InflightCount=0, and Err is unchanged.
6. RetireValid RetireReg=2 with count[2]=0 → next cycle Err=1 and count[2]=0. Err stays 1 across Flush and clears only after rst=1 for one cycle.
